// File: rtl/svi_bus_arbiter.sv
// svi_bus_arbiter: round-robin arbiter that moves one requester's x/y/z
// payload onto a shared registered bus, waits for the downstream ack, then
// inserts HOLD_CYCLES dead cycles plus one idle cycle before the next grant.
module svi_bus_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [NUM_REQ*WIDTH-1:0]   i_x,
    input  logic [NUM_REQ*WIDTH-1:0]   i_y,
    input  logic [NUM_REQ*WIDTH-1:0]   i_z,
    input  logic                       i_ack,
    output logic [NUM_REQ-1:0]         o_gnt,
    output logic [WIDTH-1:0]           o_x,
    output logic [WIDTH-1:0]           o_y,
    output logic [WIDTH-1:0]           o_z,
    output logic                       o_valid,
    output logic [$clog2(NUM_REQ)-1:0] o_src,
    output logic                       o_busy,
    output logic [15:0]                o_xfer_cnt
);

    localparam int SRC_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       gap_cnt;
    logic [SRC_W-1:0] last_winner;
    logic [SRC_W-1:0] winner;
    logic             found;

    // Round-robin search: first requester at or after last_winner+1, with wrap.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && i_req[(int'(last_winner) + k) % NUM_REQ]) begin
                winner = SRC_W'((int'(last_winner) + k) % NUM_REQ);
                found  = 1'b1;
            end
        end
    end

    // Next-state logic: IDLE arbitrates, SEND waits for ack, GAP burns dead cycles.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (found) state_nxt = ST_SEND;
            ST_SEND: if (i_ack) state_nxt = (HOLD_CYCLES > 0) ? ST_GAP : ST_IDLE;
            ST_GAP:  if (gap_cnt <= 4'd1) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Payload, grant, gap counter and transfer counter registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: every datapath register is reset here; a mid-transfer reset must drop the bus to a known all-zero state.
        if (i_rst) begin
            o_gnt       <= '0;
            o_x         <= '0;
            o_y         <= '0;
            o_z         <= '0;
            o_src       <= '0;
            o_xfer_cnt  <= '0;
            gap_cnt     <= '0;
            last_winner <= SRC_W'(NUM_REQ - 1);
        end else begin
            // Grant is a single-cycle pulse; default it low every edge.
            o_gnt <= '0;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        o_x         <= i_x[int'(winner) * WIDTH +: WIDTH];
                        o_y         <= i_y[int'(winner) * WIDTH +: WIDTH];
                        o_z         <= i_z[int'(winner) * WIDTH +: WIDTH];
                        o_src       <= winner;
                        last_winner <= winner;
                        o_gnt       <= NUM_REQ'(1) << winner;
                    end
                end
                ST_SEND: begin
                    if (i_ack) begin
                        o_xfer_cnt <= o_xfer_cnt + 16'd1;
                        gap_cnt    <= 4'(HOLD_CYCLES);
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt - 4'd1;
                end
                default: begin
                    gap_cnt <= '0;
                end
            endcase
        end
    end

    // Status flags decode straight from the state register, so reset clears them asynchronously.
    assign o_valid = (state == ST_SEND);
    assign o_busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_svi_bus_arbiter.sv
// Bench for svi_bus_arbiter: transaction-level reference model feeding a
// scoreboard queue, a monitor that pops on every grant, plus directed phases
// for fairness, single transfer, backpressure, mid-transfer reset and a
// HOLD_CYCLES=0 instance.
module tb_svi_bus_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;
    localparam int HOLD    = 2;

    logic                     i_clk = 1'b0;
    logic                     i_rst = 1'b1;
    logic [NUM_REQ-1:0]       i_req = '0;
    logic [NUM_REQ*WIDTH-1:0] i_x = '0, i_y = '0, i_z = '0;
    logic                     i_ack = 1'b0;
    logic [NUM_REQ-1:0]       o_gnt;
    logic [WIDTH-1:0]         o_x, o_y, o_z;
    logic                     o_valid;
    logic [1:0]               o_src;
    logic                     o_busy;
    logic [15:0]              o_xfer_cnt;

    // Second instance: two requesters, no dead cycles.
    logic        h0_rst = 1'b1;
    logic [1:0]  h0_req = '0;
    logic [15:0] h0_x = '0, h0_y = '0, h0_z = '0;
    logic        h0_ack = 1'b0;
    logic [1:0]  h0_gnt;
    logic [7:0]  h0_ox, h0_oy, h0_oz;
    logic        h0_valid;
    logic [0:0]  h0_src;
    logic        h0_busy;
    logic [15:0] h0_cnt;

    svi_bus_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .HOLD_CYCLES(HOLD)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_x(i_x), .i_y(i_y), .i_z(i_z),
        .i_ack(i_ack), .o_gnt(o_gnt), .o_x(o_x), .o_y(o_y), .o_z(o_z),
        .o_valid(o_valid), .o_src(o_src), .o_busy(o_busy), .o_xfer_cnt(o_xfer_cnt)
    );

    svi_bus_arbiter #(.NUM_REQ(2), .WIDTH(8), .HOLD_CYCLES(0)) dut_h0 (
        .i_clk(i_clk), .i_rst(h0_rst), .i_req(h0_req), .i_x(h0_x), .i_y(h0_y), .i_z(h0_z),
        .i_ack(h0_ack), .o_gnt(h0_gnt), .o_x(h0_ox), .o_y(h0_oy), .o_z(h0_oz),
        .o_valid(h0_valid), .o_src(h0_src), .o_busy(h0_busy), .o_xfer_cnt(h0_cnt)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    typedef struct {
        int               src;
        logic [WIDTH-1:0] x, y, z;
    } txn_t;

    typedef struct {
        int src;
        int e;
    } glog_t;

    txn_t  sb_q[$];
    glog_t glog[$];

    int edge_n   = 0;
    bit m_send   = 0;
    int m_last   = NUM_REQ - 1;
    int m_cnt    = 0;
    int m_resume = 0;   // first edge at which a new arbitration may happen

    task automatic model_step();
        edge_n++;
        if (i_rst) begin
            m_send   = 0;
            m_last   = NUM_REQ - 1;
            m_cnt    = 0;
            m_resume = 0;
            sb_q.delete();
        end else if (m_send) begin
            if (i_ack) begin
                m_send   = 0;
                m_cnt    = (m_cnt + 1) % 65536;
                m_resume = edge_n + HOLD + 1;
            end
        end else if (edge_n >= m_resume && i_req != 0) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                int w;
                w = (m_last + k) % NUM_REQ;
                if (i_req[w]) begin
                    txn_t t;
                    t.src = w;
                    t.x = i_x[w*WIDTH +: WIDTH];
                    t.y = i_y[w*WIDTH +: WIDTH];
                    t.z = i_z[w*WIDTH +: WIDTH];
                    sb_q.push_back(t);
                    m_last = w;
                    m_send = 1;
                    break;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge i_clk);
        model_step();
    end

    // ---------------- monitor ----------------
    logic [WIDTH-1:0] last_x = '0, last_y = '0, last_z = '0;
    int               last_src = 0;

    task automatic monitor_step();
        bit   exp_busy;
        txn_t t;
        if (i_rst) begin
            last_x = '0; last_y = '0; last_z = '0; last_src = 0;
            return;
        end
        exp_busy = m_send || (edge_n < m_resume - 1);
        check("valid", 32'(o_valid), 32'(m_send));
        check("busy", 32'(o_busy), 32'(exp_busy));
        check("xfer_cnt", 32'(o_xfer_cnt), 32'(m_cnt));
        if (o_gnt != 0) begin
            if (sb_q.size() == 0) begin
                check("gnt_unexpected", 32'(o_gnt), 32'd0);
            end else begin
                t = sb_q.pop_front();
                check("gnt_onehot", 32'(o_gnt), 32'(1) << t.src);
                last_x = t.x; last_y = t.y; last_z = t.z; last_src = t.src;
                glog.push_back('{src: t.src, e: edge_n});
            end
        end
        check("o_x", 32'(o_x), 32'(last_x));
        check("o_y", 32'(o_y), 32'(last_y));
        check("o_z", 32'(o_z), 32'(last_z));
        check("o_src", 32'(o_src), 32'(last_src));
    endtask

    initial forever begin
        @(negedge i_clk);
        monitor_step();
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic rand_payload();
        for (int i = 0; i < NUM_REQ; i++) begin
            i_x[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            i_y[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            i_z[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!o_valid && n < 30) begin
            tick();
            n++;
        end
        if (!o_valid) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (o_busy && n < 60) begin
            tick();
            n++;
        end
        if (o_busy) check({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        int busy_n, cnt0, rel_edge, n;
        logic [WIDTH-1:0] px, py, pz;

        tick(3);
        #2 i_rst = 1'b0;

        // Fairness from reset: all request, ack always high.
        glog.delete();
        rand_payload();
        i_req = '1;
        i_ack = 1'b1;
        tick(20);
        i_req = '0;
        check("fair_count_ge5", 32'(glog.size() >= 5), 32'd1);
        for (int i = 0; i < 5 && i < glog.size(); i++) begin
            check("fair_order", 32'(glog[i].src), 32'(i % NUM_REQ));
            if (i > 0) check("fair_spacing", 32'(glog[i].e - glog[i-1].e), 32'(1 + HOLD + 1));
        end
        i_ack = 1'b0;
        wait_idle("fair_idle");

        // Single request from requester 0, ack one cycle after valid.
        cnt0 = int'(o_xfer_cnt);
        rand_payload();
        i_x[0 +: WIDTH] = 8'hFF;
        i_y[0 +: WIDTH] = 8'h00;
        i_z[0 +: WIDTH] = 8'hFF;
        i_req = 4'b0001;
        wait_valid("single_valid");
        i_req = '0;
        check("single_gnt", 32'(o_gnt), 32'h1);
        busy_n = 1;
        tick();
        check("single_gnt_pulse", 32'(o_gnt), 32'h0);
        if (o_busy) busy_n++;
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (o_busy) busy_n++;
            tick();
        end
        check("single_busy_cycles", 32'(busy_n), 32'd4);
        check("single_x", 32'(o_x), 32'hFF);
        check("single_y", 32'(o_y), 32'h00);
        check("single_z", 32'(o_z), 32'hFF);
        check("single_src", 32'(o_src), 32'd0);
        check("single_cnt", 32'(o_xfer_cnt), 32'((cnt0 + 1) % 65536));

        // Backpressure: requester 2, ack low for 5 SEND cycles.
        rand_payload();
        px = i_x[2*WIDTH +: WIDTH];
        py = i_y[2*WIDTH +: WIDTH];
        pz = i_z[2*WIDTH +: WIDTH];
        i_req = 4'b0100;
        wait_valid("bp_valid");
        i_req = '0;
        rand_payload();
        check("bp_gnt_first", 32'(o_gnt), 32'h4);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("bp_valid_hold", 32'(o_valid), 32'd1);
            check("bp_gnt_low", 32'(o_gnt), 32'd0);
            check("bp_x_hold", 32'(o_x), 32'(px));
            check("bp_y_hold", 32'(o_y), 32'(py));
            check("bp_z_hold", 32'(o_z), 32'(pz));
            check("bp_src_hold", 32'(o_src), 32'd2);
        end
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        check("bp_valid_drop", 32'(o_valid), 32'd0);
        wait_idle("bp_idle");

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            i_req = ($urandom_range(0, 3) == 0) ? '0 : NUM_REQ'($urandom);
            rand_payload();
            i_ack = ($urandom_range(0, 2) != 0);
            tick();
        end
        i_req = '0;
        i_ack = 1'b1;
        tick(2);
        i_ack = 1'b0;
        wait_idle("rand_idle");

        // Reset in the middle of SEND.
        i_req = 4'b0100;
        rand_payload();
        wait_valid("rst_valid");
        #2 i_rst = 1'b1;
        #1;
        check("rst_async_valid", 32'(o_valid), 32'd0);
        check("rst_async_busy", 32'(o_busy), 32'd0);
        check("rst_async_cnt", 32'(o_xfer_cnt), 32'd0);
        check("rst_async_gnt", 32'(o_gnt), 32'd0);
        check("rst_async_x", 32'(o_x), 32'd0);
        check("rst_async_src", 32'(o_src), 32'd0);
        i_req = '1;
        i_ack = 1'b1;
        tick(2);
        glog.delete();
        rel_edge = edge_n;
        #2 i_rst = 1'b0;
        tick(6);
        check("rst_regrant_seen", 32'(glog.size() > 0), 32'd1);
        if (glog.size() > 0) begin
            check("rst_first_src", 32'(glog[0].src), 32'd0);
            check("rst_first_latency", 32'(glog[0].e - rel_edge), 32'd1);
        end
        i_req = '0;
        tick(2);
        i_ack = 1'b0;
        wait_idle("post_rst_idle");

        // HOLD_CYCLES=0 instance: requesters 0 and 1 held, ack always high.
        h0_x = 16'hB1A0; h0_y = 16'hB2A2; h0_z = 16'hB3A3;
        h0_req = 2'b11;
        h0_ack = 1'b1;
        #2 h0_rst = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) begin
            check("h0_gnt", 32'(h0_gnt), (k % 2 == 1) ? 32'd0 : (32'd1 << ((k / 2) % 2)));
            check("h0_valid", 32'(h0_valid), 32'(k % 2 == 0));
            check("h0_busy", 32'(h0_busy), 32'(k % 2 == 0));
            check("h0_src", 32'(h0_src), 32'((k / 2) % 2));
            check("h0_x", 32'(h0_ox), ((k / 2) % 2 == 0) ? 32'hA0 : 32'hB1);
            if (k < 7) tick();
        end
        check("h0_cnt", 32'(h0_cnt), 32'd4);
        h0_req = '0;
        tick(2);

        n = sb_q.size();
        check("scoreboard_drained", 32'(n), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/svi_bus_arbiter.md
SVI_BUS_ARBITER -- requirements
Module: svi_bus_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (range 2..8).
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the width of each x/y/z field.
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 2, giving the dead cycles after each transfer (range 0..15).
REQ-004 The block SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-005 i_clk  input  1  clock; all state changes occur on its rising edge.
REQ-006 i_rst  input  1  asynchronous active-high reset.
REQ-007 i_req  input  NUM_REQ  request per requester; bit n = requester n.
REQ-008 i_x  input  NUM_REQ*WIDTH  x payloads; slice n*WIDTH +: WIDTH belongs to requester n.
REQ-009 i_y  input  NUM_REQ*WIDTH  y payloads, same slicing.
REQ-010 i_z  input  NUM_REQ*WIDTH  z payloads, same slicing.
REQ-011 o_gnt  output  NUM_REQ  one-hot grant pulse.
REQ-012 o_x, o_y, o_z  output  WIDTH each  registered payload driven to the shared x/y/z interface.
REQ-013 o_valid  output  1  payload on o_x/o_y/o_z is valid.
REQ-014 i_ack  input  1  downstream accepts the payload.
REQ-015 o_src  output  $clog2(NUM_REQ)  index of the requester that owns the current payload.
REQ-016 o_busy  output  1  high in any state other than IDLE.
REQ-017 o_xfer_cnt  output  16  count of completed transfers.

Function
REQ-018 The FSM SHALL have three states.
- IDLE: arbitrate.
- SEND: o_valid=1, wait for i_ack.
- GAP: count HOLD_CYCLES dead cycles.
REQ-019 IDLE with i_req==0 SHALL stay in IDLE.
REQ-020 IDLE with i_req!=0 at an edge SHALL select a winner by round-robin, then in the same edge:
- register the winner's x/y/z slices into o_x/o_y/o_z;
- set o_src to the winner;
- set o_gnt to one-hot winner;
- enter SEND.
REQ-021 Latency: a request present before edge k SHALL produce o_valid=1 and o_gnt in the cycle after edge k.
REQ-022 o_gnt SHALL be high for exactly one cycle, the first cycle of SEND, and SHALL be 0 otherwise.
REQ-023 Round-robin: search starts at index (last_winner+1) mod NUM_REQ, ascending with wrap; after reset last_winner=NUM_REQ-1, so requester 0 has highest priority.
REQ-024 In SEND, o_x/o_y/o_z/o_src SHALL hold stable and o_valid SHALL stay 1 until an edge with i_ack=1.
REQ-025 i_ack is ignored while o_valid=0.
REQ-026 An edge in SEND with i_ack=1 SHALL:
- increment o_xfer_cnt by 1, wrapping 0xFFFF -> 0x0000;
- clear o_valid;
- enter GAP if HOLD_CYCLES>0, else IDLE.
REQ-027 GAP SHALL last exactly HOLD_CYCLES cycles (4-bit down-counter), then enter IDLE.
REQ-028 At least one IDLE cycle SHALL separate consecutive transfers, including when HOLD_CYCLES=0.
REQ-029 i_req changes outside IDLE SHALL be ignored.
REQ-030 A request withdrawn before the IDLE sampling edge SHALL receive no grant.
REQ-031 A requester that keeps i_req high after its grant SHALL be treated as a new request, subject to round-robin order.
REQ-032 o_x/o_y/o_z/o_src SHALL retain the last transfer's values in GAP and IDLE.

Reset
REQ-033 While i_rst=1 the block SHALL immediately and asynchronously drive:
- state IDLE;
- o_valid=0, o_gnt=0, o_busy=0;
- o_x=o_y=o_z=0, o_src=0, o_xfer_cnt=0;
- GAP counter 0, last_winner=NUM_REQ-1.
REQ-034 Reset asserted during SEND or GAP SHALL abandon the transfer without counting it.
REQ-035 The first arbitration SHALL occur at the first rising edge with i_rst=0.

Verification
REQ-036 Single request: i_req=0001, x/y/z slice0=0xFF/0x00/0xFF, i_ack=1 one cycle after o_valid SHALL give:
- o_gnt=0001 for one cycle;
- o_x=0xFF, o_y=0x00, o_z=0xFF, o_src=0;
- o_xfer_cnt=1;
- o_busy high for 1+1+2 cycles.
REQ-037 Fairness: i_req=1111 held, i_ack=1 always SHALL give grant order 0,1,2,3,0, each separated by 1 SEND + 2 GAP + 1 IDLE cycles.
REQ-038 Backpressure: i_ack=0 for 5 cycles then 1 SHALL hold o_valid=1 and constant o_x/o_y/o_z/o_src for 6 cycles, with o_gnt high only in the first.
REQ-039 HOLD_CYCLES=0 with i_req=0011 held SHALL alternate grants 0,1 with exactly one idle cycle between transfers.
REQ-040 Reset mid-SEND: i_rst pulsed while o_valid=1 SHALL give:
- o_valid=0 and o_xfer_cnt unchanged-to-0 asynchronously;
- requester 0 granted first after release.
REQ-041 Counter wrap: after 65536 transfers o_xfer_cnt SHALL read 0x0000.
